// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - multi-cycle radix-2 restoring divider for the EX stage
// Requests a pipeline stall while dividing and holds its result until EX advances.
module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             stallreq_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sign_q, sign_d;
    logic               sign_r_q, sign_r_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   quot_out_q, quot_out_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;

    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_nx, quo_nx;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush overrides everything else
    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = (divisor_i == '0) ? ZERO : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
                ZERO: state_d = DONE;
                DONE: begin
                    if (!start_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ready_d    = (state_d == DONE);
        stallreq_o = start_i & ~ready_q & ~annul_i;
        ready_o    = ready_q;
    end

    // Operand magnitudes; the most negative value maps onto itself, read as unsigned 2^(WIDTH-1)
    always_comb begin
        dvd_neg = signed_i & dividend_i[WIDTH-1];
        dvs_neg = signed_i & divisor_i[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend_i : dividend_i;
        dvs_mag = dvs_neg ? -divisor_i : divisor_i;
    end

    // One restoring step; the borrow out of the widened subtract is the compare result
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        fits   = ~diff[WIDTH];
        rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], fits};
    end

    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign_d     = sign_q;
        sign_r_d   = sign_r_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        if (annul_i) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_d    = '0;
                        rem_d    = '0;
                        dvs_d    = dvs_mag;
                        sign_d   = dvd_neg ^ dvs_neg;
                        sign_r_d = dvd_neg;
                        // A zero divisor reports the dividend untouched, so keep the raw pattern
                        quo_d    = (divisor_i == '0) ? dividend_i : dvd_mag;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == LAST_CNT) begin
                        quot_out_d = sign_q ? -quo_nx : quo_nx;
                        rem_out_d  = sign_r_q ? -rem_nx : rem_nx;
                    end
                end
                ZERO: begin
                    quot_out_d = '1;
                    rem_out_d  = quo_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign_q     <= 1'b0;
            sign_r_q   <= 1'b0;
            ready_q    <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sign_q     <= sign_d;
            sign_r_q   <= sign_r_d;
            ready_q    <= ready_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
        end
    end

    assign quotient_o  = quot_out_q;
    assign remainder_o = rem_out_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - self-checking bench for ex_div_unit
// Directed and randomized divides against an arithmetic reference model.
module tb_ex_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         annul_i;
    logic         stallreq_o;
    logic         ready_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .stallreq_o  (stallreq_o),
        .ready_o     (ready_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating division as the language defines it; remainder takes the dividend's sign
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, qq, rr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
        end
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                           input int hold, input string tag);
        logic [W-1:0] eq, er;
        int stalls;
        bit got;
        ref_div(a, b, s, eq, er);
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        stalls     = 0;
        got        = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            stalls += int'(stallreq_o);
            @(negedge clk);
            dividend_i = $urandom;
            divisor_i  = $urandom;
            signed_i   = 1'($urandom);
        end
        check({tag, "_ready"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(stalls), (b == '0) ? 64'd2 : 64'(W + 1));
        check({tag, "_quo"}, 64'(quotient_o), 64'(eq));
        check({tag, "_rem"}, 64'(remainder_o), 64'(er));
        check({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_quo"}, 64'(quotient_o), 64'(eq));
            check({tag, "_hold_rem"}, 64'(remainder_o), 64'(er));
            check({tag, "_hold_stall"}, 64'(stallreq_o), 64'd0);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    endtask

    logic [W-1:0] ra, rb;
    bit           seen;

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        annul_i    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_quo", 64'(quotient_o), 64'd0);
        check("reset_rem", 64'(remainder_o), 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        rst_n = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0, "u100_7");
        check("u100_7_const_q", 64'(quotient_o), 64'd14);
        check("u100_7_const_r", 64'(remainder_o), 64'd2);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "sm7_2");
        check("sm7_2_const_q", 64'(quotient_o), 64'hFFFF_FFFD);
        check("sm7_2_const_r", 64'(remainder_o), 64'hFFFF_FFFF);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s7_m2");
        run_div(32'h1234, 32'd0, 1'b0, 0, "u_dz");
        run_div(32'h1234, 32'd0, 1'b1, 0, "s_dz");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        check("s_ovf_const_q", 64'(quotient_o), 64'h8000_0000);
        run_div(32'd1000, 32'd9, 1'b0, 4, "hold4");

        // Flush mid-divide while EX still presents the instruction
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            seen |= ready_o;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div(32'd20, 32'd3, 1'b0, 0, "after_annul");

        // Reset in the middle of a divide
        @(negedge clk);
        start_i    = 1'b1;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        repeat (6) @(negedge clk);
        rst_n   = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy_ready", 64'(ready_o), 64'd0);
        check("rst_busy_quo", 64'(quotient_o), 64'd0);
        check("rst_busy_rem", 64'(remainder_o), 64'd0);
        check("rst_busy_stall", 64'(stallreq_o), 64'd0);
        rst_n = 1'b1;
        run_div(32'd1000, 32'd3, 1'b0, 0, "after_rst");

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 1'($urandom), $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
